// File: rtl/axil_reg_slave.sv
// AXI-Lite register file for the l3fwd control block: read-only ID word at index 0, RW control words above it.
// Optional build macro AXIL_REG_SLVERR_EN: out-of-range accesses answer SLVERR instead of OKAY.
module axil_reg_slave #(
    parameter int unsigned AXIL_ADDR_WIDTH = 24,
    parameter int unsigned AXIL_DATA_WIDTH = 32,
    parameter int unsigned AXIL_STRB_WIDTH = AXIL_DATA_WIDTH / 8,
    parameter int unsigned NUM_REGS        = 16,
    parameter logic [AXIL_DATA_WIDTH-1:0] ID_VALUE = 32'h4C33_4657
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [AXIL_ADDR_WIDTH-1:0]          s_axil_awaddr,
    input  logic [2:0]                          s_axil_awprot,
    input  logic                                s_axil_awvalid,
    output logic                                s_axil_awready,
    input  logic [AXIL_DATA_WIDTH-1:0]          s_axil_wdata,
    input  logic [AXIL_STRB_WIDTH-1:0]          s_axil_wstrb,
    input  logic                                s_axil_wvalid,
    output logic                                s_axil_wready,
    output logic [1:0]                          s_axil_bresp,
    output logic                                s_axil_bvalid,
    input  logic                                s_axil_bready,
    input  logic [AXIL_ADDR_WIDTH-1:0]          s_axil_araddr,
    input  logic [2:0]                          s_axil_arprot,
    input  logic                                s_axil_arvalid,
    output logic                                s_axil_arready,
    output logic [AXIL_DATA_WIDTH-1:0]          s_axil_rdata,
    output logic [1:0]                          s_axil_rresp,
    output logic                                s_axil_rvalid,
    input  logic                                s_axil_rready,
    output logic [NUM_REGS*AXIL_DATA_WIDTH-1:0] ctrl_regs,
    output logic [NUM_REGS-1:0]                 ctrl_wr_pulse
);

    localparam int unsigned IDX_W = AXIL_ADDR_WIDTH - 2;
    localparam int unsigned DW    = AXIL_DATA_WIDTH;
    localparam int unsigned SW    = AXIL_STRB_WIDTH;

    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_RESP = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_RESP = 1'b1;

    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_REG_SLVERR_EN
    localparam logic [1:0] RESP_OOR  = 2'b10;
`else
    localparam logic [1:0] RESP_OOR  = 2'b00;
`endif

    // write-side state
    logic [0:0]          r_wstate,   w_wstate_n;
    logic                r_awready,  w_awready_n;
    logic                r_wready,   w_wready_n;
    logic                r_bvalid,   w_bvalid_n;
    logic [1:0]          r_bresp,    w_bresp_n;
    logic                r_aw_held,  w_aw_held_n;
    logic                r_w_held,   w_w_held_n;
    logic [IDX_W-1:0]    r_aw_idx,   w_aw_idx_n;
    logic [DW-1:0]       r_wdata,    w_wdata_n;
    logic [SW-1:0]       r_wstrb,    w_wstrb_n;
    logic [NUM_REGS-1:0] r_pulse,    w_pulse_n;
    logic [DW-1:0]       r_regs   [1:NUM_REGS-1];
    logic [DW-1:0]       w_regs_n [1:NUM_REGS-1];

    // read-side state
    logic [0:0]          r_rstate,   w_rstate_n;
    logic                r_arready,  w_arready_n;
    logic                r_rvalid,   w_rvalid_n;
    logic [1:0]          r_rresp,    w_rresp_n;
    logic [DW-1:0]       r_rdata,    w_rdata_n;

    logic [IDX_W-1:0]    w_ar_idx;
    logic [DW-1:0]       w_rd_word;
    logic                w_aw_in_range;
    logic                w_ar_in_range;
    logic                w_unused_ok;

    assign w_unused_ok   = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr[1:0], s_axil_araddr[1:0]};
    assign w_ar_idx      = s_axil_araddr[AXIL_ADDR_WIDTH-1:2];
    assign w_aw_in_range = (r_aw_idx < IDX_W'(NUM_REGS));
    assign w_ar_in_range = (w_ar_idx < IDX_W'(NUM_REGS));

    // Write channel: collect AW and W in any order, commit on the edge after both are held.
    always_comb begin
        w_wstate_n  = r_wstate;
        w_bvalid_n  = r_bvalid;
        w_bresp_n   = r_bresp;
        w_aw_held_n = r_aw_held;
        w_w_held_n  = r_w_held;
        w_aw_idx_n  = r_aw_idx;
        w_wdata_n   = r_wdata;
        w_wstrb_n   = r_wstrb;
        w_pulse_n   = '0;
        w_regs_n    = r_regs;
        case (r_wstate)
            W_IDLE: begin
                if (s_axil_awvalid && r_awready) begin
                    w_aw_held_n = 1'b1;
                    w_aw_idx_n  = s_axil_awaddr[AXIL_ADDR_WIDTH-1:2];
                end
                if (s_axil_wvalid && r_wready) begin
                    w_w_held_n = 1'b1;
                    w_wdata_n  = s_axil_wdata;
                    w_wstrb_n  = s_axil_wstrb;
                end
                if (r_aw_held && r_w_held) begin
                    // index 0 and out-of-range indices match no slot, so they are dropped
                    for (int unsigned i = 1; i < NUM_REGS; i++) begin
                        if (r_aw_idx == IDX_W'(i)) begin
                            for (int unsigned b = 0; b < SW; b++) begin
                                if (r_wstrb[b]) w_regs_n[i][b*8 +: 8] = r_wdata[b*8 +: 8];
                            end
                            w_pulse_n[i] = 1'b1;
                        end
                    end
                    w_bvalid_n  = 1'b1;
                    w_bresp_n   = w_aw_in_range ? RESP_OKAY : RESP_OOR;
                    w_aw_held_n = 1'b0;
                    w_w_held_n  = 1'b0;
                    w_wstate_n  = W_RESP;
                end
            end
            W_RESP: begin
                if (s_axil_bready) begin
                    w_bvalid_n = 1'b0;
                    w_wstate_n = W_IDLE;
                end
            end
            default: w_wstate_n = W_IDLE;
        endcase
        w_awready_n = (w_wstate_n == W_IDLE) && !w_aw_held_n;
        w_wready_n  = (w_wstate_n == W_IDLE) && !w_w_held_n;
    end

    // Read mux over pre-edge register contents; out-of-range reads give zero.
    always_comb begin
        w_rd_word = '0;
        if (w_ar_idx == '0) w_rd_word = ID_VALUE;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (w_ar_idx == IDX_W'(i)) w_rd_word = r_regs[i];
        end
    end

    // Read channel FSM
    always_comb begin
        w_rstate_n = r_rstate;
        w_rvalid_n = r_rvalid;
        w_rresp_n  = r_rresp;
        w_rdata_n  = r_rdata;
        case (r_rstate)
            R_IDLE: begin
                if (s_axil_arvalid && r_arready) begin
                    w_rdata_n  = w_rd_word;
                    w_rresp_n  = w_ar_in_range ? RESP_OKAY : RESP_OOR;
                    w_rvalid_n = 1'b1;
                    w_rstate_n = R_RESP;
                end
            end
            R_RESP: begin
                if (s_axil_rready) begin
                    w_rvalid_n = 1'b0;
                    w_rstate_n = R_IDLE;
                end
            end
            default: w_rstate_n = R_IDLE;
        endcase
        w_arready_n = (w_rstate_n == R_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_aw_idx  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_pulse   <= '0;
            for (int unsigned i = 1; i < NUM_REGS; i++) r_regs[i] <= '0;
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= '0;
        end else begin
            r_wstate  <= w_wstate_n;
            r_awready <= w_awready_n;
            r_wready  <= w_wready_n;
            r_bvalid  <= w_bvalid_n;
            r_bresp   <= w_bresp_n;
            r_aw_held <= w_aw_held_n;
            r_w_held  <= w_w_held_n;
            r_aw_idx  <= w_aw_idx_n;
            r_wdata   <= w_wdata_n;
            r_wstrb   <= w_wstrb_n;
            r_pulse   <= w_pulse_n;
            r_regs    <= w_regs_n;
            r_rstate  <= w_rstate_n;
            r_arready <= w_arready_n;
            r_rvalid  <= w_rvalid_n;
            r_rresp   <= w_rresp_n;
            r_rdata   <= w_rdata_n;
        end
    end

    assign s_axil_awready = r_awready;
    assign s_axil_wready  = r_wready;
    assign s_axil_bvalid  = r_bvalid;
    assign s_axil_bresp   = r_bresp;
    assign s_axil_arready = r_arready;
    assign s_axil_rvalid  = r_rvalid;
    assign s_axil_rresp   = r_rresp;
    assign s_axil_rdata   = r_rdata;
    assign ctrl_wr_pulse  = r_pulse;

    assign ctrl_regs[DW-1:0] = ID_VALUE;
    for (genvar g = 1; g < NUM_REGS; g++) begin : g_flat
        assign ctrl_regs[g*DW +: DW] = r_regs[g];
    end

endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed bench for axil_reg_slave: table of write/read vectors plus hand-built sequences for
// channel ordering, B backpressure, read/write same-edge conflict and reset during a response.
module tb_axil_reg_slave;

    localparam logic [31:0] ID = 32'h4C33_4657;
`ifdef AXIL_REG_SLVERR_EN
    localparam logic [1:0] EXP_OOR = 2'b10;
`else
    localparam logic [1:0] EXP_OOR = 2'b00;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [23:0]  awaddr = '0;
    logic [2:0]   awprot = '0;
    logic         awvalid = 1'b0;
    logic         awready;
    logic [31:0]  wdata = '0;
    logic [3:0]   wstrb = '0;
    logic         wvalid = 1'b0;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready = 1'b0;
    logic [23:0]  araddr = '0;
    logic [2:0]   arprot = '0;
    logic         arvalid = 1'b0;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready = 1'b0;
    logic [511:0] ctrl_regs;
    logic [15:0]  ctrl_wr_pulse;

    int n_vec = 0;
    int n_err = 0;

    axil_reg_slave dut (
        .clk(clk), .rst_n(rst_n),
        .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
        .ctrl_regs(ctrl_regs), .ctrl_wr_pulse(ctrl_wr_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_wr;
        logic [23:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        logic [15:0] exp_pulse;
    } vec_t;

    vec_t vecs [0:11];

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Full write with bready high; returns the response and the pulse seen alongside bvalid.
    task automatic do_write(input logic [23:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output logic [15:0] pulse, output logic ok);
        logic aw_hs, w_hs;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        ok = 1'b0; resp = '0; pulse = '0;
        for (int c = 0; c < 20 && !ok; c++) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_hs) awvalid = 1'b0;
            if (w_hs)  wvalid  = 1'b0;
            if (bvalid) begin
                ok = 1'b1; resp = bresp; pulse = ctrl_wr_pulse;
            end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [23:0] a, output logic [31:0] d, output logic [1:0] resp,
                           output int lat, output logic ok);
        logic hs, hs_seen;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        ok = 1'b0; d = '0; resp = '0; lat = 0; hs_seen = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            hs = arvalid && arready;
            @(posedge clk); #1;
            if (hs) begin
                arvalid = 1'b0; hs_seen = 1'b1;
            end
            if (hs_seen) lat++;
            if (rvalid) begin
                ok = 1'b1; d = rdata; resp = rresp;
            end
        end
        arvalid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [511:0] id_only;
        logic [1:0]   resp;
        logic [15:0]  pulse;
        logic [31:0]  d;
        logic         ok;
        int           lat;
        int           bcnt;
        logic [15:0]  pulse_c [0:3];

        id_only = '0;
        id_only[31:0] = ID;

        vecs[0]  = '{1'b1, 24'h000008, 32'h11223344, 4'b0101, 32'h0,          2'b00,   16'h0004};
        vecs[1]  = '{1'b0, 24'h000008, 32'h0,        4'h0,    32'hDE22BE44,   2'b00,   16'h0000};
        vecs[2]  = '{1'b1, 24'h00003C, 32'hA5A5A5A5, 4'hF,    32'h0,          2'b00,   16'h8000};
        vecs[3]  = '{1'b0, 24'h00003F, 32'h0,        4'h0,    32'hA5A5A5A5,   2'b00,   16'h0000};
        vecs[4]  = '{1'b1, 24'h000000, 32'hFFFFFFFF, 4'hF,    32'h0,          2'b00,   16'h0000};
        vecs[5]  = '{1'b0, 24'h000002, 32'h0,        4'h0,    ID,             2'b00,   16'h0000};
        vecs[6]  = '{1'b1, 24'h000040, 32'h12345678, 4'hF,    32'h0,          EXP_OOR, 16'h0000};
        vecs[7]  = '{1'b0, 24'h000040, 32'h0,        4'h0,    32'h0,          EXP_OOR, 16'h0000};
        vecs[8]  = '{1'b1, 24'h000004, 32'hCAFEF00D, 4'b1000, 32'h0,          2'b00,   16'h0002};
        vecs[9]  = '{1'b0, 24'h000004, 32'h0,        4'h0,    32'hCA000000,   2'b00,   16'h0000};
        vecs[10] = '{1'b1, 24'hFFFFFC, 32'h87654321, 4'hF,    32'h0,          EXP_OOR, 16'h0000};
        vecs[11] = '{1'b0, 24'h00003C, 32'h0,        4'h0,    32'hA5A5A5A5,   2'b00,   16'h0000};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", 512'(awready), 512'(1'b0));
        check("rst_arready", 512'(arready), 512'(1'b0));
        check("rst_bvalid",  512'(bvalid), 512'(1'b0));
        check("rst_rvalid",  512'(rvalid), 512'(1'b0));
        check("rst_rdata",   512'(rdata), 512'(32'h0));
        check("rst_pulse",   512'(ctrl_wr_pulse), 512'(16'h0));
        check("rst_regs",    ctrl_regs, id_only);

        // readies rise only on the first edge after release
        #1 rst_n = 1'b1;
        #1 check("rel_awready_pre", 512'(awready), 512'(1'b0));
        @(posedge clk); #1;
        check("rel_awready", 512'(awready), 512'(1'b1));
        check("rel_wready",  512'(wready), 512'(1'b1));
        check("rel_arready", 512'(arready), 512'(1'b1));

        do_read(24'h000000, d, resp, lat, ok);
        check("id_ok", 512'(ok), 512'(1'b1));
        check("id_rdata", 512'(d), 512'(ID));
        check("id_rresp", 512'(resp), 512'(2'b00));
        check("id_latency", 512'(lat), 512'(1));

        // W arrives two cycles before AW
        wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
        check("wfirst_wready", 512'(wready), 512'(1'b1));
        @(posedge clk); #1;
        wvalid = 1'b0;
        check("wfirst_wready_held", 512'(wready), 512'(1'b0));
        @(posedge clk); #1;
        check("wfirst_no_bvalid", 512'(bvalid), 512'(1'b0));
        awaddr = 24'h000008; awvalid = 1'b1;
        check("wfirst_awready", 512'(awready), 512'(1'b1));
        @(posedge clk); #1;
        awvalid = 1'b0;
        bcnt = 0;
        for (int c = 0; c < 4; c++) begin
            if (bvalid) bcnt++;
            @(posedge clk); #1;
            pulse_c[c] = ctrl_wr_pulse;
            if (c == 0) check("wfirst_slice2", 512'(ctrl_regs[95:64]), 512'(32'hDEADBEEF));
        end
        if (bvalid) bcnt++;
        check("wfirst_bvalid_count", 512'(bcnt), 512'(1));
        check("wfirst_pulse_c0", 512'(pulse_c[0]), 512'(16'h0004));
        check("wfirst_pulse_c1", 512'(pulse_c[1]), 512'(16'h0000));

        // table-driven vectors
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, pulse, ok);
                check($sformatf("v%0d_bvalid", i), 512'(ok), 512'(1'b1));
                check($sformatf("v%0d_bresp", i), 512'(resp), 512'(vecs[i].exp_resp));
                check($sformatf("v%0d_pulse", i), 512'(pulse), 512'(vecs[i].exp_pulse));
                check($sformatf("v%0d_pulse_clr", i), 512'(ctrl_wr_pulse), 512'(16'h0));
            end else begin
                do_read(vecs[i].addr, d, resp, lat, ok);
                check($sformatf("v%0d_rvalid", i), 512'(ok), 512'(1'b1));
                check($sformatf("v%0d_rdata", i), 512'(d), 512'(vecs[i].exp_rdata));
                check($sformatf("v%0d_rresp", i), 512'(resp), 512'(vecs[i].exp_resp));
            end
        end

        // B backpressure with a second AW waiting
        bready = 1'b0;
        awaddr = 24'h000010; wdata = 32'h01010101; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(posedge clk); #1;
        check("bp_bvalid_up", 512'(bvalid), 512'(1'b1));
        check("bp_slice4", 512'(ctrl_regs[159:128]), 512'(32'h01010101));
        awaddr = 24'h000014; awvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check($sformatf("bp%0d_bvalid", c), 512'(bvalid), 512'(1'b1));
            check($sformatf("bp%0d_bresp", c), 512'(bresp), 512'(2'b00));
            check($sformatf("bp%0d_awready", c), 512'(awready), 512'(1'b0));
            check($sformatf("bp%0d_wready", c), 512'(wready), 512'(1'b0));
        end
        bready = 1'b1;
        @(posedge clk); #1;
        check("bp_bvalid_clr", 512'(bvalid), 512'(1'b0));
        check("bp_awready_back", 512'(awready), 512'(1'b1));
        check("bp_no_pulse", 512'(ctrl_wr_pulse), 512'(16'h0));
        do_write(24'h000014, 32'h00000055, 4'hF, resp, pulse, ok);
        check("bp2_bvalid", 512'(ok), 512'(1'b1));
        check("bp2_pulse", 512'(pulse), 512'(16'h0020));
        do_read(24'h000010, d, resp, lat, ok);
        check("bp_readback", 512'(d), 512'(32'h01010101));

        // AR handshake on the same edge as a write commit to reg 3
        awaddr = 24'h00000C; wdata = 32'h1; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1; rready = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 24'h00000C; arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        check("conf_bvalid", 512'(bvalid), 512'(1'b1));
        check("conf_rvalid", 512'(rvalid), 512'(1'b1));
        check("conf_rdata_old", 512'(rdata), 512'(32'h0));
        @(posedge clk); #1;
        do_read(24'h00000C, d, resp, lat, ok);
        check("conf_rdata_new", 512'(d), 512'(32'h1));

        // reset asserted while a response is pending
        bready = 1'b0;
        awaddr = 24'h000014; wdata = 32'h77; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(posedge clk); #1;
        check("mrst_bvalid_pre", 512'(bvalid), 512'(1'b1));
        #2 rst_n = 1'b0;
        #1;
        check("mrst_bvalid", 512'(bvalid), 512'(1'b0));
        check("mrst_regs", ctrl_regs, id_only);
        check("mrst_awready", 512'(awready), 512'(1'b0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        do_read(24'h000014, d, resp, lat, ok);
        check("mrst_readback", 512'(d), 512'(32'h0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
